// File: rtl/image_proc_scheduler.sv
// Round-robin scheduler sharing one image-processing datapath among NUM_REQ requesters.
// Holds each legal instruction on dp_iw for DP_LATENCY cycles and returns a tagged response.
package image_proc_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBI = 4'd3;

  typedef logic [3:0][7:0] pixelMatrix_t;

  typedef struct packed {
    logic [3:0]   opcode;
    pixelMatrix_t cellA;
    pixelMatrix_t cellB;
    logic [7:0]   userInputA;
  } instruction_t;
endpackage

module image_proc_scheduler
  import image_proc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic         [NUM_REQ-1:0]        req_valid,
  input  instruction_t [NUM_REQ-1:0]        req_instr,
  output logic         [NUM_REQ-1:0]        req_ready,
  output instruction_t                      dp_iw,
  input  pixelMatrix_t                      dp_result,
  output logic                              resp_valid,
  output logic         [$clog2(NUM_REQ)-1:0] resp_id,
  output pixelMatrix_t                      resp_result,
  output logic                              resp_err,
  input  logic                              resp_ready,
  output logic                              busy
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(DP_LATENCY + 1);

  // Handshake rule for both ports: a transfer happens in a cycle where valid and
  // ready are both high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e       state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  instruction_t dp_iw_q, dp_iw_d;
  logic         resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  pixelMatrix_t resp_result_q, resp_result_d;
  logic         resp_err_q, resp_err_d;

  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_vld;
  logic           grant_legal;
  instruction_t   grant_instr;

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDW'(j);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_instr = req_instr[grant_idx];
  assign grant_legal = (grant_instr.opcode == OP_ADD)  || (grant_instr.opcode == OP_ADDI) ||
                       (grant_instr.opcode == OP_SUB)  || (grant_instr.opcode == OP_SUBI);

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    dp_iw_d       = dp_iw_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          resp_id_d = grant_idx;
          ptr_d     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          if (grant_legal) begin
            dp_iw_d = grant_instr;
            cnt_d   = CNTW'(DP_LATENCY);
            state_d = S_EXEC;
          end else begin
            // Rejected instructions never reach the datapath.
            resp_err_d    = 1'b1;
            resp_result_d = '0;
            resp_valid_d  = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          resp_result_d = dp_result;
          resp_err_d    = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      dp_iw_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      dp_iw_q       <= dp_iw_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign dp_iw       = dp_iw_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_image_proc_scheduler.sv
// Bench for image_proc_scheduler: two instances (DP_LATENCY 1 and 3) share stimulus and
// are compared every cycle against a timeline model of grants and responses.
module tb_image_proc_scheduler;
  import image_proc_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         [N-1:0] req_valid;
  instruction_t [N-1:0] req_instr;
  logic                 resp_ready;

  logic [N-1:0] rr_o   [2];
  instruction_t iw_o   [2];
  pixelMatrix_t dres   [2];
  logic         rv_o   [2];
  logic [1:0]   rid_o  [2];
  pixelMatrix_t rres_o [2];
  logic         rerr_o [2];
  logic         busy_o [2];

  pixelMatrix_t p1 = '0;
  pixelMatrix_t p2 = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit           m_idle    [2];
  int           m_ptr     [2];
  bit           m_pend    [2];
  int           m_resp_at [2];
  int           m_id      [2];
  bit           m_err     [2];
  pixelMatrix_t m_res     [2];
  instruction_t m_iw      [2];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Datapath behaviour: per-pixel 8-bit wrapping arithmetic.
  function automatic pixelMatrix_t dp_fn(instruction_t iw);
    pixelMatrix_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (iw.opcode)
        OP_ADD:  r[i] = iw.cellA[i] + iw.cellB[i];
        OP_ADDI: r[i] = iw.cellA[i] + iw.userInputA;
        OP_SUB:  r[i] = iw.cellA[i] - iw.cellB[i];
        OP_SUBI: r[i] = iw.cellA[i] - iw.userInputA;
        default: r[i] = 8'h00;
      endcase
    end
    return r;
  endfunction

  function automatic instruction_t mk(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] u);
    instruction_t t;
    t.opcode     = op;
    t.cellA      = {4{a}};
    t.cellB      = {4{b}};
    t.userInputA = u;
    return t;
  endfunction

  function automatic instruction_t rnd_instr(int max_op);
    instruction_t t;
    t.opcode     = 4'($urandom_range(0, max_op));
    t.cellA      = $urandom;
    t.cellB      = $urandom;
    t.userInputA = 8'($urandom);
    return t;
  endfunction

  assign dres[0] = dp_fn(iw_o[0]);
  always @(posedge clk) begin
    p1 <= dp_fn(iw_o[1]);
    p2 <= p1;
  end
  assign dres[1] = p2;

  image_proc_scheduler #(.NUM_REQ(N), .DP_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_instr(req_instr), .req_ready(rr_o[0]),
    .dp_iw(iw_o[0]), .dp_result(dres[0]), .resp_valid(rv_o[0]), .resp_id(rid_o[0]),
    .resp_result(rres_o[0]), .resp_err(rerr_o[0]), .resp_ready(resp_ready), .busy(busy_o[0])
  );

  image_proc_scheduler #(.NUM_REQ(N), .DP_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_instr(req_instr), .req_ready(rr_o[1]),
    .dp_iw(iw_o[1]), .dp_result(dres[1]), .resp_valid(rv_o[1]), .resp_id(rid_o[1]),
    .resp_result(rres_o[1]), .resp_err(rerr_o[1]), .resp_ready(resp_ready), .busy(busy_o[1])
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_resp0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rv_o[0] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, " req_ready"}, rr_o[k], '0);
      check_eq({tag, " resp_valid"}, rv_o[k], 0);
      check_eq({tag, " busy"}, busy_o[k], 0);
      check_eq({tag, " dp_iw"}, iw_o[k], '0);
      check_eq({tag, " resp_id"}, rid_o[k], '0);
      check_eq({tag, " resp_result"}, rres_o[k], '0);
      check_eq({tag, " resp_err"}, rerr_o[k], 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Every falling edge: compare both instances with the model, then advance the model.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      string        pfx;
      logic [N-1:0] exp_rr;
      int           g;
      bit           vis;
      bit           legal;
      pfx = $sformatf("L%0d", lat_of(k));
      if (rst) begin
        check_eq({pfx, " rst req_ready"}, rr_o[k], '0);
        check_eq({pfx, " rst resp_valid"}, rv_o[k], 0);
        check_eq({pfx, " rst busy"}, busy_o[k], 0);
        m_idle[k] = 1'b1;
        m_ptr[k]  = 0;
        m_pend[k] = 1'b0;
        m_iw[k]   = '0;
      end else begin
        exp_rr = '0;
        g = -1;
        if (m_idle[k]) begin
          for (int j = 0; j < N; j++) begin
            int idx;
            idx = (m_ptr[k] + j) % N;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) exp_rr[g] = 1'b1;
        vis = m_pend[k] && (cyc >= m_resp_at[k]);
        check_eq({pfx, " req_ready"}, rr_o[k], exp_rr);
        check_eq({pfx, " busy"}, busy_o[k], !m_idle[k]);
        check_eq({pfx, " dp_iw"}, iw_o[k], m_iw[k]);
        check_eq({pfx, " resp_valid"}, rv_o[k], vis);
        if (vis) begin
          check_eq({pfx, " resp_id"}, rid_o[k], m_id[k]);
          check_eq({pfx, " resp_err"}, rerr_o[k], m_err[k]);
          check_eq({pfx, " resp_result"}, rres_o[k], m_res[k]);
          if (resp_ready) begin
            m_pend[k] = 1'b0;
            m_idle[k] = 1'b1;
          end
        end
        if (g >= 0) begin
          legal        = (req_instr[g].opcode <= 4'd3);
          m_idle[k]    = 1'b0;
          m_ptr[k]     = (g + 1) % N;
          m_pend[k]    = 1'b1;
          m_resp_at[k] = cyc + 1 + (legal ? lat_of(k) : 0);
          m_id[k]      = g;
          m_err[k]     = !legal;
          m_res[k]     = legal ? dp_fn(req_instr[g]) : '0;
          if (legal) m_iw[k] = req_instr[g];
        end
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    bit ok;
    req_valid  = '0;
    req_instr  = '0;
    resp_ready = 1'b1;
    rst        = 1'b1;
    #1;
    check_reset_outputs("por");
    step(3);
    rst = 1'b0;

    // Single ADD from requester 2: 10 + 3 in every pixel.
    step(1);
    req_instr[2] = mk(OP_ADD, 8'd10, 8'd3, 8'd0);
    req_valid    = 4'b0100;
    wait_resp0(ok);
    check_eq("add resp seen", ok, 1);
    check_eq("add resp_id", rid_o[0], 2);
    check_eq("add resp_result", rres_o[0], 32'h0d0d0d0d);
    check_eq("add resp_err", rerr_o[0], 0);
    step(1);
    req_valid = '0;
    step(10);

    // All requesters valid continuously.
    for (int i = 0; i < N; i++) req_instr[i] = rnd_instr(3);
    req_valid = 4'b1111;
    step(24);
    req_valid = '0;
    step(10);

    // Illegal opcode from requester 3.
    req_instr[3] = mk(4'hF, 8'd7, 8'd7, 8'd7);
    req_valid    = 4'b1000;
    wait_resp0(ok);
    check_eq("illegal resp seen", ok, 1);
    check_eq("illegal resp_err", rerr_o[0], 1);
    check_eq("illegal resp_result", rres_o[0], '0);
    check_eq("illegal resp_id", rid_o[0], 3);
    step(1);
    req_valid = '0;
    step(10);

    // Response back-pressure on SUBI 50 - 20.
    resp_ready   = 1'b0;
    req_instr[0] = mk(OP_SUBI, 8'd50, 8'd0, 8'd20);
    req_valid    = 4'b0001;
    wait_resp0(ok);
    check_eq("bp resp seen", ok, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp resp_valid", rv_o[0], 1);
      check_eq("bp resp_id", rid_o[0], 0);
      check_eq("bp resp_result", rres_o[0], 32'h1e1e1e1e);
      check_eq("bp req_ready", rr_o[0], '0);
    end
    step(1);
    resp_ready = 1'b1;
    req_valid  = '0;
    step(12);

    // Randomized traffic with back-pressure and mixed legal/illegal opcodes.
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_instr[i] = rnd_instr(5);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    step(12);

    // Reset while the latency-3 instance is executing.
    req_instr[0] = mk(OP_ADD, 8'd1, 8'd2, 8'd0);
    req_valid    = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rr_o[1] != '0) ok = 1'b1;
    end
    check_eq("midexec grant seen", ok, 1);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    req_instr[1] = mk(OP_ADD, 8'd4, 8'd4, 8'd0);
    req_instr[3] = mk(OP_SUB, 8'd9, 8'd4, 8'd0);
    req_valid    = 4'b1010;
    #1;
    check_reset_outputs("async rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post-rst grant L1", rr_o[0], 4'b0010);
    check_eq("post-rst grant L3", rr_o[1], 4'b0010);
    step(1);
    req_valid = '0;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/image_proc_scheduler.md
# image_proc_scheduler

Round-robin instruction scheduler that shares the single image-processing datapath among `NUM_REQ` requesters. It accepts one `instruction_t` at a time via valid/ready, holds it on the datapath for `DP_LATENCY` cycles, and captures the `pixelMatrix_t` result. It then returns the result to the winning requester with a tagged response handshake. Illegal opcodes are rejected without being issued to the datapath. The block sits between the requester ports (host/DMA command sources) and the datapath instruction input.

## Interface

- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DP_LATENCY`, default 1: cycles from `dp_iw` change to a valid `dp_result`; must be ≥1.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester instruction valid.
- `req_instr`, in, `NUM_REQ` × `instruction_t`: per-requester instruction.
- `req_ready`, out, `NUM_REQ`: one-hot grant; handshake for requester i when `req_valid[i] && req_ready[i]`.
- `dp_iw`, out, `instruction_t`: registered instruction driven to the datapath.
- `dp_result`, in, `pixelMatrix_t`: datapath result.
- `resp_valid`, out, 1: response available.
- `resp_id`, out, `$clog2(NUM_REQ)`: index of the requester that owns the response.
- `resp_result`, out, `pixelMatrix_t`: captured result; all zeros on error.
- `resp_err`, out, 1: set when the opcode was not ADD, ADDI, SUB or SUBI.
- `resp_ready`, in, 1: response consumer ready.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- **States:** IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first set index searching upward from `ptr` and wrapping modulo `NUM_REQ`. Assert `req_ready` for that index only; this is combinational from `req_valid` and `ptr`.
  - On the handshake, register `dp_iw <= req_instr[g]`, `resp_id <= g`, and `ptr <= (g+1) mod NUM_REQ`.
  - If the opcode is legal, load `cnt <= DP_LATENCY` and go to EXEC.
  - If the opcode is illegal, leave `dp_iw` unchanged, set `resp_err=1` and `resp_result=0`, and go directly to RESP.
- **EXEC:**
  - `dp_iw` is held stable and `cnt` decrements each cycle.
  - In the cycle where `cnt==1`, register `resp_result <= dp_result` and `resp_err <= 0`, then go to RESP.
- **RESP:**
  - `resp_valid=1`; `resp_id`, `resp_result` and `resp_err` are held stable until `resp_ready`.
  - On the handshake, go to IDLE.
- `req_ready` is all zeros outside IDLE.
- `dp_iw` keeps its last issued value in IDLE and RESP; it is never modified by a rejected instruction.
- `ptr` advances only on a granted handshake. A requester that drops `req_valid` before being granted loses nothing, because arbitration is re-evaluated every IDLE cycle.
- Requesters must hold `req_instr[i]` stable while `req_valid[i]` is high.

## Timing

- **Reset values (asynchronous, immediate):**
  - state=IDLE, `ptr`=0, `cnt`=0.
  - `dp_iw`=0, `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_err`=0.
  - `busy`=0, `req_ready`=0 while `rst` is high.
- **Legal instruction, latency:**
  - Grant at cycle T.
  - `dp_iw` is valid from cycle T+1.
  - Result is captured at the end of cycle T+`DP_LATENCY`.
  - `resp_valid` is high from cycle T+`DP_LATENCY`+1.
- **Illegal instruction:** `resp_valid` is high from cycle T+1.
- **Throughput:**
  - The next grant can occur no earlier than the cycle after the RESP handshake.
  - With `resp_ready` tied high, the minimum spacing between grants is `DP_LATENCY`+2 cycles.
- **Simultaneous events:**
  - `resp_ready` already high when `resp_valid` rises: the handshake completes in that cycle and the block is IDLE the next cycle.
  - No grant is given in the same cycle as a RESP handshake.
- **Reset mid-operation:** the in-flight instruction is abandoned, no response is produced, and arbitration restarts at requester 0.
- **Wrap-around:** after granting index `NUM_REQ`-1, `ptr` returns to 0.

## Test plan

- **Reset:** assert `rst` asynchronously mid-EXEC.
  - All outputs go to their reset values immediately.
  - After release, with `req_valid`=4'b1010, requester 1 is granted first.
- **Single ADD:** requester 2 issues ADD with cellA all pixels=10 and cellB all pixels=3, `DP_LATENCY`=1, `resp_ready`=1.
  - `req_ready`=4'b0100 at T.
  - `resp_valid` at T+2 with `resp_id`=2, every pixel=13, `resp_err`=0.
- **Round-robin fairness:** all four requesters hold `req_valid` continuously.
  - Grants occur in order 0,1,2,3,0.
  - Each grant is spaced exactly `DP_LATENCY`+2 cycles apart.
- **Illegal opcode:** requester 3 sends an opcode outside {ADD, ADDI, SUB, SUBI}.
  - `resp_valid` at T+1 with `resp_err`=1 and `resp_result`=0.
  - `dp_iw` is unchanged from its previous value.
- **Response back-pressure:** SUBI with cellA=50 and userInputA=20; `resp_ready` held low for 5 cycles.
  - `resp_valid`, `resp_id` and `resp_result` (all 30) stay stable.
  - `req_ready` stays 0.
  - IDLE is re-entered the cycle after `resp_ready` rises.
- **Latency parameter:** set `DP_LATENCY`=3 with a bench model that delays `dp_result` by 3 cycles.
  - The captured result equals the delayed value.
  - `resp_valid` rises at T+4.
